rr_mux_4_1_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 data multiplexer among four valid/ready requesters and drives a single registered valid/ready output. Each cycle it selects one requester, steers that requester's data through the 4:1 mux using a 2-bit select, and captures the result into a one-entry output register. It sits in front of any single-consumer resource that four producers contend for.

---
 rtl/rr_mux_4_1_arbiter_if.sv | 43 ++++
 rtl/rr_mux_4_1_arbiter.sv | 90 +++++++++
 tb/tb_rr_mux_4_1_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_4_1_arbiter_if.sv
// rtl/rr_mux_4_1_arbiter_if.sv - requester/consumer handshake bundle for the 4:1 round-robin arbiter
interface rr_mux_4_1_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_id;
    logic             out_ready;

    // Environment side: drives requests and consumer ready.
    modport master (
        output in_valid,
        output in_data0,
        output in_data1,
        output in_data2,
        output in_data3,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_id
    );

    // Arbiter side.
    modport slave (
        input  in_valid,
        input  in_data0,
        input  in_data1,
        input  in_data2,
        input  in_data3,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_id
    );
endinterface

// File: rtl/rr_mux_4_1_arbiter.sv
// rtl/rr_mux_4_1_arbiter.sv - round-robin 4:1 mux arbiter with one-entry registered output
module rr_mux_4_1_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_mux_4_1_arbiter_if.slave   bus
);
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [1:0]       out_id_q;
    logic [1:0]       out_id_d;

    logic             load_en;
    logic             grant_found;
    logic [1:0]       grant;
    logic [WIDTH-1:0] mux_data;
    logic             transfer;

    // Output register may accept new data when empty or being drained this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    // Grant search: first valid requester starting at ptr, wrapping mod 4.
    always_comb begin
        grant_found = 1'b0;
        grant       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr_q + 2'(k);
            if (!grant_found && bus.in_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    // 4:1 data mux steered by the grant index.
    always_comb begin
        mux_data = bus.in_data0;
        case (grant)
            2'd0:    mux_data = bus.in_data0;
            2'd1:    mux_data = bus.in_data1;
            2'd2:    mux_data = bus.in_data2;
            default: mux_data = bus.in_data3;
        endcase
    end

    // Reset gates the accept so nothing looks accepted while state is being cleared.
    assign transfer     = rst_n && load_en && grant_found;
    assign bus.in_ready = transfer ? (4'b0001 << grant) : 4'b0000;

    // Next-state: load on transfer, clear valid on a drain with nothing behind it.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (transfer) begin
            ptr_d       = grant + 2'd1;
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_id_d    = grant;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; asynchronous clear discards any in-flight output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_rr_mux_4_1_arbiter.sv
// tb/tb_rr_mux_4_1_arbiter.sv - directed self-checking bench for rr_mux_4_1_arbiter
module tb_rr_mux_4_1_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_mux_4_1_arbiter_if #(.WIDTH(4)) bus ();

    rr_mux_4_1_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data0  = 4'hA;
        bus.in_data1  = 4'hB;
        bus.in_data2  = 4'hC;
        bus.in_data3  = 4'hD;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        checks++;
        if (bus.out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_id: got %0d expected 0", bus.out_id);
        end
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;
        step();
    endtask

    task automatic test_single;
        bus.in_valid = 4'b0100;
        bus.in_data2 = 4'hC;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_in_ready: got %b expected 0100", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hC || bus.out_id !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h id=%0d expected v=1 d=c id=2",
                     bus.out_valid, bus.out_data, bus.out_id);
        end
        // ptr must now be 3: with everyone requesting, requester 3 wins.
        bus.in_valid = 4'b1111;
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_ptr3: got %b expected 1000", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_id !== 2'd3 || bus.out_data !== 4'hD) begin
            errors++;
            $display("FAIL single_wrap: got d=%h id=%0d expected d=d id=3",
                     bus.out_data, bus.out_id);
        end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_data [6];
        logic [1:0] exp_id   [6];
        exp_data = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data[i] || bus.out_id !== exp_id[i]) begin
                errors++;
                $display("FAIL rotation_%0d: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_id, exp_data[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        // ptr is 2 here; only requester 1 asks, so it is granted.
        bus.in_valid = 4'b0010;
        step();
        checks++;
        if (bus.out_data !== 4'hB || bus.out_id !== 2'd1) begin
            errors++;
            $display("FAIL bp_load: got d=%h id=%0d expected d=b id=1", bus.out_data, bus.out_id);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %b expected 0000", i, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hB || bus.out_id !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d expected v=1 d=b id=1",
                         i, bus.out_valid, bus.out_data, bus.out_id);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_grant: got %b expected 0100", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_data !== 4'hC || bus.out_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_out: got d=%h id=%0d expected d=c id=2", bus.out_data, bus.out_id);
        end
    endtask

    task automatic test_wrap_skip;
        bus.in_valid = 4'b1001;
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant3: got %b expected 1000", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_id !== 2'd3 || bus.out_data !== 4'hD) begin
            errors++;
            $display("FAIL wrap_out3: got d=%h id=%0d expected d=d id=3", bus.out_data, bus.out_id);
        end
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant0: got %b expected 0001", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_id !== 2'd0 || bus.out_data !== 4'hA) begin
            errors++;
            $display("FAIL wrap_out0: got d=%h id=%0d expected d=a id=0", bus.out_data, bus.out_id);
        end
        bus.in_valid = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hA || bus.out_id !== 2'd0) begin
            errors++;
            $display("FAIL drain: got v=%b d=%h id=%0d expected v=0 d=a id=0",
                     bus.out_valid, bus.out_data, bus.out_id);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays_empty: got v=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        // ptr is 1; requester 2 alone loads id 2.
        bus.in_valid = 4'b0100;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup: got v=%b id=%0d expected v=1 id=2", bus.out_valid, bus.out_id);
        end
        bus.in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async_clear: got v=%b rdy=%b expected v=0 rdy=0000",
                     bus.out_valid, bus.in_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b expected 0001", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 4'hA) begin
            errors++;
            $display("FAIL mid_first_out: got v=%b d=%h id=%0d expected v=1 d=a id=0",
                     bus.out_valid, bus.out_data, bus.out_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
